// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RV32I 5-stage pipeline sequencer for load-use, redirect flush and memory-wait freeze.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters; otherwise they read 0.
module hazard_ctrl #(
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic             pc_en,
  output logic             pc_redirect,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  logic [0:0] state_q, state_d;
  logic [3:0] fl_left_q, fl_left_d;
  logic       lu_hit, redir, stall, in_fl;
  always_comb begin
    lu_hit = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    redir = (state_q == RUN) && !mem_busy && branch_taken;
    stall = (state_q == RUN) && !mem_busy && !branch_taken && lu_hit;
    in_fl = (state_q == FLUSH) && !mem_busy;
    pc_en       = rst_n && !mem_busy && !stall;
    pc_redirect = rst_n && redir;
    if_id_en    = rst_n && !mem_busy && !stall;
    if_id_flush = !rst_n || redir || in_fl;
    id_ex_en    = rst_n && !mem_busy;
    id_ex_flush = !rst_n || redir || stall;
    ex_mem_en   = rst_n && !mem_busy;
    state_d   = redir ? (IMEM_LAT > 0 ? FLUSH : RUN) :
                in_fl ? (fl_left_q == 4'd1 ? RUN : FLUSH) : state_q;
    fl_left_d = redir ? 4'(IMEM_LAT) : in_fl ? fl_left_q - 4'd1 : fl_left_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      fl_left_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      fl_left_q <= fl_left_d;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir || in_fl) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl built with IMEM_LAT=2.
module tb_hazard_ctrl;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  // Control vector order: {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
  localparam logic [6:0] NORM   = 7'b1010101;
  localparam logic [6:0] RSTV   = 7'b0001010;
  localparam logic [6:0] STALL  = 7'b0000111;
  localparam logic [6:0] REDIR  = 7'b1111111;
  localparam logic [6:0] FLUSHC = 7'b1011101;
  localparam logic [6:0] FRZ    = 7'b0000000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] id_rs = 5'd0, id_rs2 = 5'd9, ex_rd = 5'd0;
  logic id_use_rs = 1'b1, id_use_rs2 = 1'b1, ex_mem_read = 1'b0;
  logic branch_taken = 1'b0, mem_busy = 1'b0;
  logic pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [6:0] ctl, e;
  logic [6:0] exp_q[$];
  int n_vec = 0, n_err = 0;
  int m_stall = 0, m_flush = 0;
  bit pend_r = 1'b0, pend_s = 1'b0, pend_f = 1'b0;
  hazard_ctrl #(.IMEM_LAT(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rs2(id_rs2),
    .id_use_rs(id_use_rs), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_en(pc_en), .pc_redirect(pc_redirect), .if_id_en(if_id_en),
    .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  assign ctl = {pc_en, pc_redirect, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};
  // Row: {rst_n, branch_taken, mem_busy, ex_mem_read, ex_rd[4:0], id_rs[4:0], expected ctl[6:0]}
  task automatic apply(input logic [20:0] row);
    @(posedge clk);
    if (pend_r) begin
      m_stall += int'(pend_s);
      m_flush += int'(pend_f);
    end else begin
      m_stall = 0;
      m_flush = 0;
    end
    #1;
    {rst_n, branch_taken, mem_busy, ex_mem_read, ex_rd, id_rs} = row[20:7];
    exp_q.push_back(row[6:0]);
    pend_r = row[20];
    pend_s = (row[6:0] == STALL);
    pend_f = row[3] && !row[18];
    @(negedge clk);
  endtask
  task automatic test_reset;
    logic [20:0] v[4] = '{{4'b0110, 5'd5, 5'd5, RSTV}, {4'b0110, 5'd5, 5'd5, RSTV},
                          {4'b0100, 5'd0, 5'd0, RSTV}, {4'b1000, 5'd0, 5'd0, NORM}};
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_vec++;
      if (ctl !== e) begin n_err++; $display("FAIL reset[%0d] ctl got=%b exp=%b", i, ctl, e); end
    end
    n_vec++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++; $display("FAIL reset counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask
  task automatic test_load_use;
    logic [20:0] v[6] = '{{4'b1001, 5'd5, 5'd5, STALL}, {4'b1000, 5'd5, 5'd5, NORM},
                          {4'b1001, 5'd0, 5'd0, NORM},  {4'b1001, 5'd9, 5'd3, STALL},
                          {4'b1001, 5'd7, 5'd5, NORM},  {4'b1000, 5'd0, 5'd0, NORM}};
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_vec++;
      if (ctl !== e) begin n_err++; $display("FAIL load_use[%0d] ctl got=%b exp=%b", i, ctl, e); end
    end
    n_vec++;
    if (stall_cnt !== CNT_W'(PERF ? m_stall : 0)) begin
      n_err++; $display("FAIL load_use stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? m_stall : 0);
    end
  endtask
  task automatic test_branch;
    logic [20:0] v[5] = '{{4'b1100, 5'd0, 5'd0, REDIR}, {4'b1100, 5'd0, 5'd0, FLUSHC},
                          {4'b1000, 5'd0, 5'd0, FLUSHC}, {4'b1000, 5'd0, 5'd0, NORM},
                          {4'b1000, 5'd0, 5'd0, NORM}};
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_vec++;
      if (ctl !== e) begin n_err++; $display("FAIL branch[%0d] ctl got=%b exp=%b", i, ctl, e); end
    end
    n_vec++;
    if (flush_cnt !== CNT_W'(PERF ? m_flush : 0)) begin
      n_err++; $display("FAIL branch flush_cnt got=%0d exp=%0d", flush_cnt, PERF ? m_flush : 0);
    end
  endtask
  task automatic test_freeze_flush;
    logic [20:0] v[8] = '{{4'b1100, 5'd0, 5'd0, REDIR}, {4'b1000, 5'd0, 5'd0, FLUSHC},
                          {4'b1010, 5'd0, 5'd0, FRZ},    {4'b1110, 5'd0, 5'd0, FRZ},
                          {4'b1011, 5'd5, 5'd5, FRZ},    {4'b1010, 5'd0, 5'd0, FRZ},
                          {4'b1000, 5'd0, 5'd0, FLUSHC}, {4'b1000, 5'd0, 5'd0, NORM}};
    int f0;
    f0 = m_flush;
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_vec++;
      if (ctl !== e) begin n_err++; $display("FAIL freeze[%0d] ctl got=%b exp=%b", i, ctl, e); end
    end
    n_vec++;
    if (flush_cnt !== CNT_W'(PERF ? m_flush : 0) || m_flush - f0 != 3) begin
      n_err++; $display("FAIL freeze flush_cnt got=%0d exp=%0d", flush_cnt, PERF ? m_flush : 0);
    end
  endtask
  task automatic test_priority;
    logic [20:0] v[7] = '{{4'b1101, 5'd5, 5'd5, REDIR}, {4'b1001, 5'd5, 5'd5, FLUSHC},
                          {4'b1101, 5'd5, 5'd5, FLUSHC}, {4'b1000, 5'd0, 5'd0, NORM},
                          {4'b1111, 5'd5, 5'd5, FRZ},    {4'b1001, 5'd5, 5'd5, STALL},
                          {4'b1000, 5'd0, 5'd0, NORM}};
    int s0;
    s0 = m_stall;
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_vec++;
      if (ctl !== e) begin n_err++; $display("FAIL priority[%0d] ctl got=%b exp=%b", i, ctl, e); end
      if (i == 4) begin
        n_vec++;
        if (stall_cnt !== CNT_W'(PERF ? s0 : 0)) begin
          n_err++; $display("FAIL priority stall_cnt got=%0d exp=%0d", stall_cnt, PERF ? s0 : 0);
        end
      end
    end
  endtask
  task automatic test_reset_abort;
    logic [20:0] v[4] = '{{4'b1100, 5'd0, 5'd0, REDIR}, {4'b0010, 5'd0, 5'd0, RSTV},
                          {4'b1000, 5'd0, 5'd0, NORM},  {4'b1001, 5'd5, 5'd5, STALL}};
    foreach (v[i]) begin
      apply(v[i]);
      e = exp_q.pop_front();
      n_vec++;
      if (ctl !== e) begin n_err++; $display("FAIL reset_abort[%0d] ctl got=%b exp=%b", i, ctl, e); end
    end
    n_vec++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      n_err++; $display("FAIL reset_abort counters got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask
  initial begin
    test_reset;
    test_load_use;
    test_branch;
    test_freeze_flush;
    test_priority;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
